// File: rtl/spm_ctrl_pkg.sv
// Shared types and sizing helpers for the spm sequencer.
// Counter width and RUN length both follow from WIDTH and PIPE_LAT.
package spm_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE,
    CLEAR,
    RUN,
    DONE
  } state_e;

  function automatic int run_len(input int w, input int pl);
    return 2 * w + pl;
  endfunction

  function automatic int cnt_width(input int w, input int pl);
    return $clog2(2 * w + pl + 1);
  endfunction

endpackage

// File: rtl/spm_ctrl_shift.sv
// y serialiser and product deserialiser for the spm sequencer.
// SPM_CTRL_SIGNED_EN: y shifts arithmetically (sign-extends b).
module spm_ctrl_shift
  import spm_ctrl_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load_i,
  input  logic               shift_i,
  input  logic               capture_i,
  input  logic [WIDTH-1:0]   b_i,
  input  logic               p_i,
  output logic               y_o,
  output logic [2*WIDTH-1:0] prod_o
);

  logic [WIDTH-1:0]   y_q;
  logic [2*WIDTH-1:0] p_q;
  logic               fill;

`ifdef SPM_CTRL_SIGNED_EN
  assign fill = y_q[WIDTH-1];
`else
  assign fill = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      y_q <= '0;
      p_q <= '0;
    end else begin
      if (load_i)
        y_q <= b_i;
      else if (shift_i)
        y_q <= {fill, y_q[WIDTH-1:1]};
      // bits arrive LSB-first; entering at the MSB leaves bit k at prod[k]
      if (capture_i)
        p_q <= {p_i, p_q[2*WIDTH-1:1]};
    end
  end

  assign y_o    = y_q[0];
  assign prod_o = p_q;

endmodule

// File: rtl/spm_ctrl.sv
// Sequencer for the serial-parallel multiplier array.
// Define SPM_CTRL_SIGNED_EN for two's-complement operands.
module spm_ctrl
  import spm_ctrl_pkg::*;
#(
  parameter int WIDTH    = 32,
  parameter int PIPE_LAT = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] prod,
  output logic [WIDTH-1:0]   spm_x,
  output logic               spm_y,
  output logic               spm_clr,
  input  logic               spm_p
);

  localparam int CW = cnt_width(WIDTH, PIPE_LAT);
  localparam int RL = run_len(WIDTH, PIPE_LAT);
  localparam logic [CW-1:0] LAST = CW'(RL - 1);
  localparam logic [CW-1:0] PLAT = CW'(PIPE_LAT);

  state_e           state_q;
  logic [CW-1:0]    cnt_q;
  logic             in_ready_q;
  logic             out_valid_q;
  logic             clr_q;
  logic [WIDTH-1:0] x_q;
  logic             accept;
  logic             running;
  logic             capture;
  logic             y_bit;

  assign accept  = (state_q == IDLE) && in_valid;
  assign running = (state_q == RUN);
  assign capture = running && (cnt_q >= PLAT);

  spm_ctrl_shift #(
    .WIDTH(WIDTH)
  ) u_shift (
    .clk      (clk),
    .rst      (rst),
    .load_i   (accept),
    .shift_i  (running),
    .capture_i(capture),
    .b_i      (b),
    .p_i      (spm_p),
    .y_o      (y_bit),
    .prod_o   (prod)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      clr_q       <= 1'b0;
      x_q         <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (in_valid) begin
            x_q        <= a;
            in_ready_q <= 1'b0;
            clr_q      <= 1'b1;
            cnt_q      <= '0;
            state_q    <= CLEAR;
          end
        end
        CLEAR: begin
          clr_q   <= 1'b0;
          cnt_q   <= '0;
          state_q <= RUN;
        end
        RUN: begin
          if (cnt_q == LAST) begin
            out_valid_q <= 1'b1;
            state_q     <= DONE;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // reset forces the handshake closed and the array cleared immediately
  assign in_ready  = in_ready_q & rst;
  assign spm_clr   = clr_q | ~rst;
  assign out_valid = out_valid_q;
  assign spm_x     = x_q;
  assign spm_y     = running & y_bit;

endmodule

// File: tb/tb_spm_ctrl.sv
// Scoreboard bench for spm_ctrl with a behavioural spm array model.
// Define SPM_CTRL_SIGNED_EN to exercise the signed build.
module tb_spm_ctrl;

  localparam int W  = 8;
  localparam int PL = 1;

  logic           clk = 1'b0;
  logic           rst = 1'b0;
  logic           in_valid = 1'b0;
  logic           out_ready = 1'b1;
  logic           spm_p = 1'b0;
  logic [W-1:0]   a = '0;
  logic [W-1:0]   b = '0;
  logic           in_ready;
  logic           out_valid;
  logic [2*W-1:0] prod;
  logic [W-1:0]   spm_x;
  logic           spm_y;
  logic           spm_clr;

  spm_ctrl #(
    .WIDTH(W),
    .PIPE_LAT(PL)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .a        (a),
    .b        (b),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .prod     (prod),
    .spm_x    (spm_x),
    .spm_y    (spm_y),
    .spm_clr  (spm_clr),
    .spm_p    (spm_p)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  logic [2*W-1:0] exp_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  function automatic logic [2*W-1:0] model(input logic [W-1:0] x,
                                           input logic [W-1:0] y);
    longint sx;
    longint sy;
`ifdef SPM_CTRL_SIGNED_EN
    sx = longint'($signed(x));
    sy = longint'($signed(y));
`else
    sx = longint'(x);
    sy = longint'(y);
`endif
    return (2*W)'(sx * sy);
  endfunction

  // array: accumulates x*y_k*2^k; bit k is final once y_k is in
  longint acc = 0;
  int     k = 0;
  always @(posedge clk) begin
    longint xe;
`ifdef SPM_CTRL_SIGNED_EN
    xe = longint'($signed(spm_x));
`else
    xe = longint'(spm_x);
`endif
    if (spm_clr) begin
      acc = 0;
      k = 0;
      spm_p <= 1'b0;
    end else begin
      if (spm_y) acc = acc + (xe << k);
      spm_p <= acc[k];
      if (k < 63) k = k + 1;
    end
  end

  always @(negedge clk)
    if (rst && in_valid && in_ready)
      exp_q.push_back(model(a, b));

  always @(negedge clk)
    if (rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_unexpected: got %0h expected none", prod);
      end else begin
        chk("sb_prod", prod, exp_q.pop_front());
      end
    end

  task automatic send(input logic [W-1:0] av, input logic [W-1:0] bv,
                      output int acc_cyc);
    int n;
    @(posedge clk);
    #1;
    in_valid = 1'b1;
    a = av;
    b = bv;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!in_ready && n < 200);
    if (n >= 200) chk("send_timeout", 64'(n), 0);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    acc_cyc = cyc;
  endtask

  task automatic wait_valid(input logic [W-1:0] ax, output int n,
                            output bit ir_ok, output bit xs_ok);
    n = 0;
    ir_ok = 1'b1;
    xs_ok = 1'b1;
    do begin
      @(negedge clk);
      n++;
      if (in_ready !== 1'b0) ir_ok = 1'b0;
      if (spm_x !== ax) xs_ok = 1'b0;
    end while (out_valid !== 1'b1 && n < 200);
    if (n >= 200) chk("valid_timeout", 64'(n), 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int t1, t2, n;
    bit ir_ok, xs_ok;
    bit v_ok, p_ok, r_ok;
    logic [2*W-1:0] p0;
    logic [W-1:0] ra, rb;

    repeat (3) @(negedge clk);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_prod", prod, 0);
    chk("rst_spm_x", spm_x, 0);
    chk("rst_spm_y", spm_y, 0);
    chk("rst_spm_clr", spm_clr, 1);
    @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    chk("idle_in_ready", in_ready, 1);
    chk("idle_spm_clr", spm_clr, 0);

    send(8'd3, 8'd5, t1);
    wait_valid(8'd3, n, ir_ok, xs_ok);
    chk("latency", 64'(n), 19);
    chk("prod_3x5", prod, 16'h000F);
    chk("busy_in_ready", ir_ok, 1);
    chk("spm_x_held", xs_ok, 1);

    send(8'hFF, 8'hFF, t1);
    wait_valid(8'hFF, n, ir_ok, xs_ok);
`ifdef SPM_CTRL_SIGNED_EN
    chk("prod_ffxff", prod, 16'h0001);
`else
    chk("prod_ffxff", prod, 16'hFE01);
`endif
    send(8'h00, 8'hA5, t1);
    wait_valid(8'h00, n, ir_ok, xs_ok);
    chk("prod_0xa5", prod, 16'h0000);

`ifdef SPM_CTRL_SIGNED_EN
    send(8'hFD, 8'd5, t1);
    wait_valid(8'hFD, n, ir_ok, xs_ok);
    chk("prod_m3x5", prod, 16'hFFF1);
    send(8'h80, 8'h80, t1);
    wait_valid(8'h80, n, ir_ok, xs_ok);
    chk("prod_m128sq", prod, 16'h4000);
`endif

    send(8'd7, 8'd9, t1);
    send(8'd200, 8'd3, t2);
    chk("b2b_period", 64'(t2 - t1), 20);
    wait_valid(8'd200, n, ir_ok, xs_ok);
    chk("b2b_in_ready", ir_ok, 1);
`ifndef SPM_CTRL_SIGNED_EN
    chk("prod_200x3", prod, 16'd600);
`endif

    for (int i = 0; i < 20; i++) begin
      ra = W'($urandom);
      rb = W'($urandom);
      send(ra, rb, t1);
      n = 0;
      while (exp_q.size() != 0 && n < 300) begin
        @(posedge clk);
        #1 out_ready = 1'($urandom_range(0, 1));
        @(negedge clk);
        n++;
      end
      if (n >= 300) chk("drain_timeout", 64'(n), 0);
      @(posedge clk);
      #1 out_ready = 1'b1;
    end

    out_ready = 1'b0;
    send(8'h5A, 8'h33, t1);
    wait_valid(8'h5A, n, ir_ok, xs_ok);
    p0 = prod;
    chk("hold_prod_val", p0, model(8'h5A, 8'h33));
    v_ok = 1'b1;
    p_ok = 1'b1;
    r_ok = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      in_valid = 1'b1;
      a = W'($urandom);
      b = W'($urandom);
      @(negedge clk);
      if (out_valid !== 1'b1) v_ok = 1'b0;
      if (prod !== p0) p_ok = 1'b0;
      if (in_ready !== 1'b0) r_ok = 1'b0;
    end
    chk("hold_valid", v_ok, 1);
    chk("hold_prod", p_ok, 1);
    chk("hold_in_ready", r_ok, 1);
    chk("hold_spm_x", spm_x, 8'h5A);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("release_valid", out_valid, 0);
    v_ok = 1'b1;
    repeat (30) begin
      @(negedge clk);
      if (out_valid !== 1'b0) v_ok = 1'b0;
    end
    chk("ignored_input", v_ok, 1);

    send(8'd9, 8'd7, t1);
    repeat (7) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("abort_valid", out_valid, 0);
    chk("abort_clr", spm_clr, 1);
    chk("abort_in_ready", in_ready, 0);
    @(negedge clk);
    exp_q.delete();
    @(posedge clk);
    #1 rst = 1'b1;
    v_ok = 1'b1;
    repeat (30) begin
      @(negedge clk);
      if (out_valid !== 1'b0) v_ok = 1'b0;
    end
    chk("no_partial", v_ok, 1);
    send(8'd2, 8'd3, t1);
    wait_valid(8'd2, n, ir_ok, xs_ok);
    chk("prod_after_rst", prod, 16'd6);

    repeat (5) @(negedge clk);
    chk("sb_empty", 64'(exp_q.size()), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
